// File: rtl/elevator_pkg.sv
// Shared elevator definitions used by the button front end, request latch and controller.
//   NUM_FLOORS              : number of floors / call buttons
//   DEFAULT_DEBOUNCE_CYCLES : default button stability window in clk cycles
//   floor_idx_t             : floor index type
//   floor_vec_t             : one bit per floor
package elevator_pkg;

    localparam int unsigned NUM_FLOORS              = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int unsigned FLOOR_IDX_W             = 2;

    typedef logic [FLOOR_IDX_W-1:0] floor_idx_t;
    typedef logic [NUM_FLOORS-1:0]  floor_vec_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: input synchroniser, stability counter, debounced level and press pulse.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   i_raw   : raw asynchronous button contact
//   o_level : debounced level (registered)
//   o_press : one-cycle pulse on each debounced 0->1 transition (registered)
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_press;

    logic                   w_sync;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_level_nxt;
    logic                   w_press_nxt;

    // Synchroniser chain; the last stage is the only copy of the input the filter sees.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Count consecutive disagreeing samples; any agreement restarts the window.
    always_comb begin
        w_cnt_nxt   = '0;
        w_level_nxt = r_level;
        w_press_nxt = 1'b0;
        if (w_sync != r_level) begin
            if (r_cnt == CNT_LAST) begin
                w_level_nxt = w_sync;
                w_press_nxt = w_sync;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // Filter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_press <= w_press_nxt;
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/button_debounce.sv
// Debounce front end for the floor call buttons: one independent channel per floor.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   raw_button : raw asynchronous contacts, bit n = floor n, active-high
//   level      : debounced levels
//   press      : one-cycle pulse per debounced press, bit n feeds request latch button<n>
module button_debounce
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] raw_button,
    output logic [NUM_FLOORS-1:0] level,
    output logic [NUM_FLOORS-1:0] press
);

    floor_vec_t w_level;
    floor_vec_t w_press;

    // One identical filter per floor button; channels never interact.
    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (raw_button[g]),
            .o_level (w_level[g]),
            .o_press (w_press[g])
        );
    end

    assign level = w_level;
    assign press = w_press;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

    localparam int unsigned DC = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned CW = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] raw_button = 4'b0000;
    logic [3:0] level;
    logic [3:0] press;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model: level flips once the last DC synchronised samples all disagree with it.
    logic [3:0] raw_q[$];
    logic [3:0] sync_q[$];
    logic [3:0] m_level;
    logic [3:0] m_press;

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW),
        .SYNC_STAGES     (SS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_button (raw_button),
        .level      (level),
        .press      (press)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b exp=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        raw_q.delete();
        sync_q.delete();
        for (int i = 0; i < int'(SS); i++) raw_q.push_back(4'b0000);
        for (int i = 0; i < int'(DC); i++) sync_q.push_back(4'b0000);
        m_level = 4'b0000;
        m_press = 4'b0000;
    endtask

    task automatic model_edge(input logic [3:0] raw_s);
        logic [3:0] s;
        logic [3:0] nl;
        bit         all_diff;
        raw_q.push_back(raw_s);
        // sync seen at this edge is the raw sample taken SS edges earlier
        s = raw_q[raw_q.size() - 1 - SS];
        sync_q.push_back(s);
        while (raw_q.size() > SS + 1) void'(raw_q.pop_front());
        while (sync_q.size() > DC) void'(sync_q.pop_front());
        nl = m_level;
        for (int n = 0; n < 4; n++) begin
            all_diff = 1'b1;
            foreach (sync_q[i]) if (sync_q[i][n] == m_level[n]) all_diff = 1'b0;
            if (all_diff) nl[n] = ~m_level[n];
        end
        m_press = nl & ~m_level;
        m_level = nl;
    endtask

    // Apply raw for one edge, advance the model, compare just after the edge.
    task automatic cycle(input logic [3:0] raw_v);
        raw_button = raw_v;
        @(posedge clk);
        if (!reset) model_clear();
        else        model_edge(raw_v);
        #1;
        check("level", level, m_level);
        check("press", press, m_press);
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        #1;
        model_clear();
        check("rst_level", level, 4'b0000);
        check("rst_press", press, 4'b0000);
    endtask

    initial begin
        int pcnt;
        logic [3:0] hold_val;
        int hold_len[4];

        // Reset held with all buttons pressed, then released.
        raw_button = 4'b1111;
        assert_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111);
            check("rst_hold_lvl", level, 4'b0000);
        end
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cycle(4'b1111);
            if (i == 5) check("rst_pre_press", press, 4'b0000);
            if (i == 6) begin
                check("rst_rise_press", press, 4'b1111);
                check("rst_rise_level", level, 4'b1111);
            end
            if (i == 7) check("rst_press_clr", press, 4'b0000);
        end
        for (int i = 0; i < 10; i++) cycle(4'b0000);
        check("idle_level", level, 4'b0000);

        // Clean press on floor 2, then release.
        pcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(4'b0100);
            if (press[2]) pcnt++;
            if (i == 5) check("clean_pre", level, 4'b0000);
            if (i == 6) check("clean_press", press, 4'b0100);
        end
        check("clean_pcnt", 4'(pcnt), 4'd1);
        check("clean_held", level, 4'b0100);
        pcnt = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(4'b0000);
            if (press[2]) pcnt++;
            if (i == 5) check("rel_pre", level, 4'b0100);
            if (i == 6) check("rel_fall", level, 4'b0000);
        end
        check("rel_pcnt", 4'(pcnt), 4'd0);

        // Bounce on floor 0: short runs restart the window.
        pcnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000);
            if (press[0]) pcnt++;
        end
        for (int i = 1; i <= 12; i++) begin
            cycle(4'b0001);
            if (press[0]) pcnt++;
            if (i == 5) check("bnc_pre", level, 4'b0000);
            if (i == 6) check("bnc_press", press, 4'b0001);
        end
        check("bnc_pcnt", 4'(pcnt), 4'd1);
        for (int i = 0; i < 10; i++) cycle(4'b0000);

        // Glitch on floor 1 shorter than the window.
        pcnt = 0;
        for (int i = 0; i < 13; i++) begin
            cycle((i < 3) ? 4'b0010 : 4'b0000);
            if (press[1] || level[1]) pcnt++;
        end
        check("glitch_cnt", 4'(pcnt), 4'd0);

        // Floors 3 and 1 together.
        for (int i = 1; i <= 10; i++) begin
            cycle(4'b1010);
            if (i == 6) check("conc_press", press, 4'b1010);
            if (i > 6)  check("conc_level", level, 4'b1010);
        end
        for (int i = 0; i < 10; i++) cycle(4'b0000);

        // Reset in the middle of a count on floor 3.
        pcnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1000);
            if (press[3]) pcnt++;
        end
        check("midrst_pre", 4'(pcnt), 4'd0);
        raw_button = 4'b1000;
        assert_reset();
        cycle(4'b1000);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cycle(4'b1000);
            if (i == 5) check("midrst_early", press, 4'b0000);
            if (i == 6) check("midrst_press", press, 4'b1000);
        end
        for (int i = 0; i < 10; i++) cycle(4'b0000);

        // Random bouncy contacts with occasional reset pulses.
        hold_val = 4'b0000;
        for (int n = 0; n < 4; n++) hold_len[n] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 4; n++) begin
                hold_len[n]--;
                if (hold_len[n] <= 0) begin
                    hold_val[n] = ~hold_val[n];
                    hold_len[n] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(DC + 2, 3 * DC))
                                                              : int'($urandom_range(1, DC + 1));
                end
            end
            if ($urandom_range(0, 399) == 0) begin
                raw_button = hold_val;
                assert_reset();
                cycle(hold_val);
                reset = 1'b1;
            end else begin
                cycle(hold_val);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
